// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encoding for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_SHIFT = 3'b001;
    localparam logic [2:0] OP_BNEG  = 3'b010;
    localparam logic [2:0] OP_NOR   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per step.
// prod_next is the accumulator value after this cycle's step.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod_next,
    output logic                 last
);
    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    assign prod_next = acc_d;
    assign last      = step && (cnt_q == SHW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops plus an iterative multiply with BUSY.
// Results and flags update only on the DONE pulse.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] INPUTA,
    input  logic [WIDTH-1:0] INPUTB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] OUT,
    output logic             ZERO,
    output logic             NEG,
    output logic             CARRY
);
    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               carry_q, carry_d;

    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic [WIDTH:0]     sum, diff;
    logic [SHW-1:0]     shamt;

    logic               mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0] prod;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .load      (mul_load),
        .step      (mul_step),
        .a         (INPUTA),
        .b         (INPUTB),
        .prod_next (prod),
        .last      (mul_last)
    );

    always_comb begin
        sum   = {1'b0, INPUTA} + {1'b0, INPUTB};
        diff  = {1'b0, INPUTA} - {1'b0, INPUTB};
        shamt = INPUTB[SHW-1:0];
        res   = '0;
        res_c = 1'b0;
        unique case (OP)
            OP_AND:   res = INPUTA & INPUTB;
            OP_SHIFT: begin
                if (INPUTB[SHW]) begin
                    res = $signed(INPUTA) >>> shamt;
                end else begin
                    res = INPUTA << shamt;
                end
            end
            OP_BNEG:  res = {{(WIDTH-1){1'b0}}, INPUTA[WIDTH-1]};
            OP_NOR:   res = ~(INPUTA | INPUTB);
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                res_c = ~diff[WIDTH];
            end
            OP_MUL:   res = '0;
            OP_SLT: begin
                res = {{(WIDTH-1){1'b0}},
                       ($signed(INPUTA) < $signed(INPUTB))};
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        out_d    = out_q;
        carry_d  = carry_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    if (OP == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = MUL;
                    end else begin
                        out_d   = res;
                        carry_d = res_c;
                        done_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    out_d   = prod[WIDTH-1:0];
                    carry_d = |prod[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
        // Flags must hold too, so reset's ZERO=0 survives until a result.
        zero_d = done_d ? (out_d == '0) : zero_q;
        neg_d  = done_d ? out_d[WIDTH-1] : neg_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
        end
    end

    assign BUSY  = (state_q == MUL);
    assign DONE  = done_q;
    assign OUT   = out_q;
    assign ZERO  = zero_q;
    assign NEG   = neg_q;
    assign CARRY = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver queues expected results,
// monitor checks every DONE, BUSY and hold behaviour.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int SW = $clog2(W);

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         START = 1'b0;
    logic [2:0]   OP = 3'b000;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         BUSY, DONE, ZERO, NEG, CARRY;
    logic [W-1:0] OUT;

    typedef struct {
        int           ecyc;
        logic [W-1:0] out;
        logic         c;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    int busy_until = 0;
    int mul_k = 0;

    alu_seq #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .OP      (OP),
        .INPUTA  (A),
        .INPUTB  (B),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .OUT     (OUT),
        .ZERO    (ZERO),
        .NEG     (NEG),
        .CARRY   (CARRY)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(logic [2:0] op,
                                   logic [W-1:0] a,
                                   logic [W-1:0] b);
        exp_t e;
        int ua, ub, sa, sb, sh, r;
        logic [31:0] rv;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        sh = int'(b[SW-1:0]);
        e.c = 1'b0;
        r = 0;
        case (op)
            OP_AND:   r = ua & ub;
            OP_SHIFT: r = b[SW] ? (sa >>> sh) : (ua << sh);
            OP_BNEG:  r = (ua >= (1 << (W - 1))) ? 1 : 0;
            OP_NOR:   r = ~(ua | ub);
            OP_ADD: begin
                r = ua + ub;
                e.c = (r >= (1 << W));
            end
            OP_SUB: begin
                r = ua - ub;
                e.c = (ua >= ub);
            end
            OP_MUL: begin
                r = ua * ub;
                e.c = (r >= (1 << W));
            end
            default:  r = (sa < sb) ? 1 : 0;
        endcase
        rv = r;
        e.out = rv[W-1:0];
        e.ecyc = 0;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     nm, act, exp, edge_cnt);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        edge_cnt++;
        @(negedge CLK);
    endtask

    task automatic cyc(bit st, logic [2:0] op,
                       logic [W-1:0] a, logic [W-1:0] b,
                       bit ovr = 1'b0,
                       logic [W-1:0] eo = '0, bit ec = 1'b0);
        exp_t e;
        int k;
        START = st;
        OP = op;
        A = a;
        B = b;
        k = edge_cnt + 1;
        if (st && RESET_N && k > busy_until) begin
            e = model(op, a, b);
            if (ovr) begin
                e.out = eo;
                e.c = ec;
            end
            if (op == OP_MUL) begin
                e.ecyc = k + W;
                busy_until = k + W;
                mul_k = k;
            end else begin
                e.ecyc = k;
            end
            q.push_back(e);
        end
        tick();
        START = 1'b0;
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_busy"}, BUSY, 0);
        chk({nm, "_done"}, DONE, 0);
        chk({nm, "_out"}, OUT, 0);
        chk({nm, "_zero"}, ZERO, 0);
        chk({nm, "_neg"}, NEG, 0);
        chk({nm, "_carry"}, CARRY, 0);
    endtask

    initial begin : monitor
        logic [W-1:0] lo;
        logic lz, ln, lc;
        exp_t e;
        lo = '0; lz = 0; ln = 0; lc = 0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                lo = '0; lz = 0; ln = 0; lc = 0;
            end else begin
                chk("busy", BUSY,
                    (edge_cnt >= mul_k && edge_cnt < busy_until));
                if (DONE) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL spurious_done: got DONE=1 expected no DONE at edge %0d",
                                 edge_cnt);
                    end else begin
                        e = q.pop_front();
                        chk("done_edge", edge_cnt, e.ecyc);
                        chk("out", OUT, e.out);
                        chk("zero", ZERO, (e.out == '0));
                        chk("neg", NEG, e.out[W-1]);
                        chk("carry", CARRY, e.c);
                        lo = e.out;
                        lz = (e.out == '0);
                        ln = e.out[W-1];
                        lc = e.c;
                    end
                end else begin
                    if (q.size() != 0 && q[0].ecyc <= edge_cnt) begin
                        e = q.pop_front();
                        n_chk++;
                        n_fail++;
                        $display("FAIL missed_done: got DONE=0 expected DONE at edge %0d",
                                 e.ecyc);
                    end
                    chk("hold_out", OUT, lo);
                    chk("hold_zero", ZERO, lz);
                    chk("hold_neg", NEG, ln);
                    chk("hold_carry", CARRY, lc);
                end
            end
        end
    end

    initial begin : driver
        int t;
        RESET_N = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        RESET_N = 1'b1;

        cyc(1, OP_NOR,   8'h2D, 8'hB4, 1, 8'h42, 0);
        cyc(1, OP_SHIFT, 8'h5C, 8'h04, 1, 8'hC0, 0);
        cyc(1, OP_SHIFT, 8'h5C, 8'h0C, 1, 8'h05, 0);
        cyc(1, OP_SHIFT, 8'hDC, 8'h0C, 1, 8'hFD, 0);
        cyc(1, OP_ADD,   8'h1C, 8'h89, 1, 8'hA5, 0);
        cyc(1, OP_ADD,   8'hFF, 8'h01, 1, 8'h00, 1);
        cyc(1, OP_SUB,   8'h05, 8'h07, 1, 8'hFE, 0);
        cyc(1, OP_BNEG,  8'hDC, 8'h00, 1, 8'h01, 0);
        cyc(1, OP_BNEG,  8'h5C, 8'h00, 1, 8'h00, 0);
        cyc(1, OP_SUB,   8'h07, 8'h07, 1, 8'h00, 1);
        cyc(1, OP_SLT,   8'hF0, 8'h01, 1, 8'h01, 0);
        cyc(1, OP_AND,   8'hF0, 8'h3C, 1, 8'h30, 0);
        cyc(0, OP_AND,   8'h00, 8'h00);

        // START during BUSY must be dropped; operand changes too.
        cyc(1, OP_MUL, 8'd13, 8'd11, 1, 8'h8F, 0);
        for (int i = 1; i <= W; i++) begin
            cyc(i % 2, OP_ADD, 8'(i * 17), 8'(i * 3));
        end
        cyc(1, OP_ADD, 8'h1C, 8'h89, 1, 8'hA5, 0);
        cyc(1, OP_MUL, 8'd20, 8'd20, 1, 8'h90, 1);
        for (int i = 0; i < W; i++) begin
            cyc(0, OP_AND, 8'h00, 8'h00);
        end

        cyc(1, OP_MUL, 8'h37, 8'h59);
        for (int i = 0; i < 3; i++) begin
            cyc(0, OP_AND, 8'h00, 8'h00);
        end
        #2;
        RESET_N = 1'b0;
        q.delete();
        busy_until = 0;
        mul_k = 0;
        #1;
        chk_all_zero("midmul_reset");
        tick();
        tick();
        chk_all_zero("held_reset");
        RESET_N = 1'b1;
        cyc(1, OP_ADD, 8'h1C, 8'h09, 1, 8'h25, 0);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0,
                3'($urandom_range(0, 7)),
                8'($urandom), 8'($urandom));
        end

        t = 0;
        while (q.size() != 0 && t < 4 * W) begin
            cyc(0, OP_AND, 8'h00, 8'h00);
            t++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results expected 0",
                     q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
